// File: rtl/sine_seq_pkg.sv
// Shared definitions for the sine tone sequencer.
//   state_t          : sequencer FSM states
//   HA_*             : host register addresses
//   SA_*             : sine generator register addresses
//   RUN_IRQ / OFF    : generator control words (run + irq enable / stopped)
//   clamp_len()      : limits a host LEN write to the table depth
package sine_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_STEP,
    S_ENABLE,
    S_WAIT_IRQ,
    S_ACK_READ,
    S_ACK_CLEAR,
    S_NEXT,
    S_STOP_WR
  } state_t;

  localparam logic [3:0] HA_CTRL   = 4'd0;
  localparam logic [3:0] HA_STATUS = 4'd1;
  localparam logic [3:0] HA_CLEAR  = 4'd2;
  localparam logic [3:0] HA_LEN    = 4'd3;
  localparam logic [3:0] HA_LAST   = 4'd4;

  localparam logic [1:0] SA_STEP   = 2'd0;
  localparam logic [1:0] SA_CTRL   = 2'd1;
  localparam logic [1:0] SA_CLEAR  = 2'd2;
  localparam logic [1:0] SA_STATUS = 2'd3;

  localparam logic [31:0] RUN_IRQ = 32'd3;
  localparam logic [31:0] OFF     = 32'd0;

  function automatic logic [3:0] clamp_len(input logic [31:0] value, input int depth);
    if (value > 32'(depth)) return 4'(depth);
    return value[3:0];
  endfunction

endpackage

// File: rtl/sine_seq_table.sv
// Tone table: DEPTH x 32-bit entries, {duration[31:16], step[15:0]}.
//   clk, rst_n : clock, async active-low reset (entries clear to 0)
//   we, waddr, wdata : host write port
//   haddr, hdata     : host asynchronous read port
//   idx, entry       : sequencer asynchronous read port
module sine_seq_table
  import sine_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] haddr,
  output logic [31:0]   hdata,
  input  logic [AW-1:0] idx,
  output logic [31:0]   entry
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign hdata = mem[haddr];
  assign entry = mem[idx];

endmodule

// File: rtl/sine_tone_sequencer.sv
// Plays up to DEPTH (step, duration) tones on the sine generator by mastering
// its 4-register slave port, counting generator period interrupts per entry.
//
// Build option: SEQ_LOOP_EN -- implements the CTRL.LOOP bit (wrap to entry 0
// after the last entry). Undefined: LOOP reads 0 and the run always ends.
//
// Ports:
//   Clk, ResetN                         : clock, async active-low reset
//   ChipSelect/Write/Read/Address/WriteData/ReadData : host slave port
//   irq                                 : sequence-done interrupt (DONE & IRQ_EN)
//   sw_ChipSelect/sw_Write/sw_Read/sw_Address/sw_WriteData/sw_ReadData : generator master port
//   sw_irq                              : generator period interrupt
//
// state       | meaning
// IDLE        | waiting for START
// LOAD_STEP   | write entry step to generator, load period counter
// ENABLE      | start generator with irq enabled (first entry only)
// WAIT_IRQ    | waiting for a generator period interrupt
// ACK_READ    | read generator status
// ACK_CLEAR   | clear generator interrupt
// NEXT        | count the period, then continue / advance / wrap / finish
// STOP_WR     | stop the generator
module sine_tone_sequencer
  import sine_seq_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int STEP_W = 16,
  parameter int DUR_W  = 16
) (
  input  logic        Clk,
  input  logic        ResetN,
  input  logic        ChipSelect,
  input  logic        Write,
  input  logic        Read,
  input  logic [3:0]  Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        irq,
  output logic        sw_ChipSelect,
  output logic        sw_Write,
  output logic        sw_Read,
  output logic [1:0]  sw_Address,
  output logic [31:0] sw_WriteData,
  input  logic [31:0] sw_ReadData,
  input  logic        sw_irq
);

  localparam int AW = $clog2(DEPTH);

  state_t             state, state_nxt;
  logic [3:0]         len;
  logic               irq_en, loop_en, done, first, stop_pend, rd_pend;
  logic [2:0]         idx;
  logic [DUR_W-1:0]   cnt, cnt_dec, dur;
  logic [STEP_W-1:0]  step;
  logic [31:0]        last, entry, tbl_rd, rd_mux;
  logic               host_wr, host_rd, wr_ctrl, start_req, stop_req, busy, launch, idx_last;

  assign host_wr   = ChipSelect & Write;
  assign host_rd   = ChipSelect & Read;
  assign wr_ctrl   = host_wr && (Address == HA_CTRL);
  // STOP wins over a simultaneous START
  assign start_req = wr_ctrl & WriteData[0] & ~WriteData[1];
  assign stop_req  = wr_ctrl & WriteData[1];
  assign busy      = (state != S_IDLE);
  assign launch    = (state == S_IDLE) && start_req && (len != 4'd0);
  assign step      = entry[STEP_W-1:0];
  assign dur       = entry[STEP_W +: DUR_W];
  assign cnt_dec   = cnt - DUR_W'(1);
  assign idx_last  = (({1'b0, idx} + 4'd1) >= len);
  assign irq       = done & irq_en;

  sine_seq_table #(.DEPTH(DEPTH)) u_table (
    .clk   (Clk),
    .rst_n (ResetN),
    .we    (host_wr & Address[3]),
    .waddr (Address[AW-1:0]),
    .wdata (WriteData),
    .haddr (Address[AW-1:0]),
    .hdata (tbl_rd),
    .idx   (idx[AW-1:0]),
    .entry (entry)
  );

`ifdef SEQ_LOOP_EN
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN)      loop_en <= 1'b0;
    else if (wr_ctrl) loop_en <= WriteData[2];
  end
`else
  assign loop_en = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    sw_ChipSelect = 1'b0;
    sw_Write      = 1'b0;
    sw_Read       = 1'b0;
    sw_Address    = '0;
    sw_WriteData  = '0;
    case (state)
      S_IDLE:      if (launch) state_nxt = S_LOAD_STEP;
      S_LOAD_STEP: begin
        sw_ChipSelect = 1'b1;
        sw_Write      = 1'b1;
        sw_Address    = SA_STEP;
        sw_WriteData  = 32'(step);
        state_nxt     = first ? S_ENABLE : S_WAIT_IRQ;
      end
      S_ENABLE: begin
        sw_ChipSelect = 1'b1;
        sw_Write      = 1'b1;
        sw_Address    = SA_CTRL;
        sw_WriteData  = RUN_IRQ;
        state_nxt     = S_WAIT_IRQ;
      end
      S_WAIT_IRQ:  if (sw_irq) state_nxt = S_ACK_READ;
      S_ACK_READ: begin
        sw_ChipSelect = 1'b1;
        sw_Read       = 1'b1;
        sw_Address    = SA_STATUS;
        state_nxt     = S_ACK_CLEAR;
      end
      S_ACK_CLEAR: begin
        sw_ChipSelect = 1'b1;
        sw_Write      = 1'b1;
        sw_Address    = SA_CLEAR;
        sw_WriteData  = 32'd1;
        state_nxt     = S_NEXT;
      end
      S_NEXT: begin
        if (cnt_dec != '0)  state_nxt = S_WAIT_IRQ;
        else if (!idx_last) state_nxt = S_LOAD_STEP;
        else if (loop_en)   state_nxt = S_LOAD_STEP;
        else                state_nxt = S_STOP_WR;
      end
      S_STOP_WR: begin
        sw_ChipSelect = 1'b1;
        sw_Write      = 1'b1;
        sw_Address    = SA_CTRL;
        sw_WriteData  = OFF;
        state_nxt     = S_IDLE;
      end
      default:     state_nxt = S_IDLE;
    endcase
    // a pending host STOP diverts whatever transition comes next
    if (stop_pend && busy && (state != S_STOP_WR)) state_nxt = S_STOP_WR;
  end

  always_comb begin
    rd_mux = '0;
    if (Address[3]) begin
      rd_mux = tbl_rd;
    end else begin
      case (Address)
        HA_CTRL:   rd_mux = {28'd0, irq_en, loop_en, 2'b00};
        HA_STATUS: begin
          rd_mux[0]     = busy;
          rd_mux[1]     = done;
          rd_mux[6:4]   = idx;
          rd_mux[31:16] = 16'(cnt);
        end
        HA_LEN:    rd_mux = 32'(len);
        HA_LAST:   rd_mux = last;
        default:   rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state     <= S_IDLE;
      len       <= '0;
      irq_en    <= 1'b0;
      done      <= 1'b0;
      first     <= 1'b0;
      stop_pend <= 1'b0;
      rd_pend   <= 1'b0;
      idx       <= '0;
      cnt       <= '0;
      last      <= '0;
      ReadData  <= '0;
    end else begin
      state     <= state_nxt;
      rd_pend   <= (state == S_ACK_READ);
      stop_pend <= (stop_pend | (stop_req & busy)) & (state != S_STOP_WR);
      if (rd_pend) last     <= sw_ReadData;
      if (host_rd) ReadData <= rd_mux;
      if (wr_ctrl) irq_en   <= WriteData[3];
      if (host_wr && (Address == HA_LEN)) len <= clamp_len(WriteData, DEPTH);
      if (host_wr && (Address == HA_CLEAR) && WriteData[0]) done <= 1'b0;
      if (launch) begin
        idx   <= '0;
        done  <= 1'b0;
        first <= 1'b1;
      end
      if (state == S_LOAD_STEP) begin
        cnt   <= (dur == '0) ? DUR_W'(1) : dur;
        first <= 1'b0;
      end
      if (state == S_NEXT) begin
        cnt <= cnt_dec;
        if (state_nxt == S_LOAD_STEP) idx <= idx_last ? 3'd0 : idx + 3'd1;
        if ((state_nxt == S_STOP_WR) && !stop_pend) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sine_tone_sequencer.sv
module tb_sine_tone_sequencer;

  logic        Clk = 1'b0;
  logic        ResetN;
  logic        ChipSelect, Write, Read;
  logic [3:0]  Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        irq;
  logic        sw_ChipSelect, sw_Write, sw_Read;
  logic [1:0]  sw_Address;
  logic [31:0] sw_WriteData;
  logic [31:0] sw_ReadData;
  logic        sw_irq;

  typedef struct packed {
    logic        w;
    logic        r;
    logic [1:0]  a;
    logic [31:0] d;
  } sw_t;

  sw_t         sw_q[$];
  logic [31:0] rd_q[$];
  logic [3:0]  rda_q[$];
  int          tests = 0;
  int          fails = 0;
  int          gen_cnt = 0;
  bit          rd_due = 1'b0;

`ifdef SEQ_LOOP_EN
  localparam logic [31:0] CTRL_RB = 32'hC;
`else
  localparam logic [31:0] CTRL_RB = 32'h8;
`endif

  sine_tone_sequencer dut (
    .Clk           (Clk),
    .ResetN        (ResetN),
    .ChipSelect    (ChipSelect),
    .Write         (Write),
    .Read          (Read),
    .Address       (Address),
    .WriteData     (WriteData),
    .ReadData      (ReadData),
    .irq           (irq),
    .sw_ChipSelect (sw_ChipSelect),
    .sw_Write      (sw_Write),
    .sw_Read       (sw_Read),
    .sw_Address    (sw_Address),
    .sw_WriteData  (sw_WriteData),
    .sw_ReadData   (sw_ReadData),
    .sw_irq        (sw_irq)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_w(input logic [1:0] a, input logic [31:0] d);
    sw_q.push_back('{w: 1'b1, r: 1'b0, a: a, d: d});
  endtask

  task automatic push_ack();
    sw_q.push_back('{w: 1'b0, r: 1'b1, a: 2'd3, d: 32'd0});
    sw_q.push_back('{w: 1'b1, r: 1'b0, a: 2'd2, d: 32'd1});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic host_write(input logic [3:0] a, input logic [31:0] d);
    ChipSelect = 1'b1; Write = 1'b1; Address = a; WriteData = d;
    @(posedge Clk); #1;
    ChipSelect = 1'b0; Write = 1'b0; Address = '0; WriteData = '0;
  endtask

  task automatic host_read(input logic [3:0] a, input logic [31:0] exp);
    rd_q.push_back(exp);
    rda_q.push_back(a);
    ChipSelect = 1'b1; Read = 1'b1; Address = a;
    @(posedge Clk); #1;
    ChipSelect = 1'b0; Read = 1'b0; Address = '0;
  endtask

  // raise the generator interrupt and hold it until the sequencer clears it
  task automatic fire_irq();
    bit seen;
    seen = 1'b0;
    sw_irq = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge Clk);
      if (sw_ChipSelect && sw_Write && sw_Address == 2'd2) seen = 1'b1;
    end
    sw_irq = 1'b0;
    check("irq_serviced", 32'(seen), 32'd1);
    @(posedge Clk); #1;
    idle(3);
  endtask

  // generator model: new status word on every read
  initial begin
    sw_ReadData = '0;
    forever begin
      @(negedge Clk);
      if (sw_ChipSelect && sw_Read) begin
        gen_cnt++;
        sw_ReadData = 32'hA5A5_0000 + 32'(gen_cnt);
      end
    end
  end

  // master-bus monitor
  initial begin
    sw_t got, exp;
    forever begin
      @(negedge Clk);
      if (sw_ChipSelect) begin
        got = {sw_Write, sw_Read, sw_Address, sw_WriteData};
        tests++;
        if (sw_q.size() == 0) begin
          fails++;
          $display("FAIL sw_bus unexpected access got w=%0b r=%0b a=%0d d=%h", got.w, got.r, got.a, got.d);
        end else begin
          exp = sw_q.pop_front();
          if (got !== exp) begin
            fails++;
            $display("FAIL sw_bus got w=%0b r=%0b a=%0d d=%h expected w=%0b r=%0b a=%0d d=%h",
                     got.w, got.r, got.a, got.d, exp.w, exp.r, exp.a, exp.d);
          end
        end
      end
    end
  end

  // host read-data monitor (ReadData valid the cycle after Read)
  initial begin
    logic [31:0] e;
    logic [3:0]  a;
    forever begin
      @(negedge Clk);
      if (rd_due) begin
        tests++;
        if (rd_q.size() == 0) begin
          fails++;
          $display("FAIL host_rd unexpected data %h", ReadData);
        end else begin
          e = rd_q.pop_front();
          a = rda_q.pop_front();
          if (ReadData !== e) begin
            fails++;
            $display("FAIL host_rd addr=%0d got %h expected %h", a, ReadData, e);
          end
        end
      end
      rd_due = ChipSelect && Read;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ResetN = 1'b0; ChipSelect = 1'b0; Write = 1'b0; Read = 1'b0;
    Address = '0; WriteData = '0; sw_irq = 1'b0;
    idle(2);
    check("reset_ReadData", ReadData, 32'd0);
    check("reset_ctl_outs", 32'({irq, sw_ChipSelect, sw_Write, sw_Read, sw_Address}), 32'd0);
    check("reset_sw_wdata", sw_WriteData, 32'd0);
    ResetN = 1'b1;
    idle(1);
    host_read(4'd1, 32'h0);
    host_read(4'd3, 32'h0);

    // single entry, 2 periods, step 16, irq enabled
    host_write(4'd3, 32'd1);
    host_write(4'd8, 32'h0002_0010);
    push_w(2'd0, 32'd16);
    push_w(2'd1, 32'd3);
    push_ack();
    push_ack();
    push_w(2'd1, 32'd0);
    host_write(4'd0, 32'h9);
    @(negedge Clk);
    check("start_to_step_write", 32'({sw_ChipSelect, sw_Write, sw_Address}), 32'hC);
    fire_irq();
    fire_irq();
    idle(3);
    host_read(4'd1, 32'h2);
    check("irq_done", 32'(irq), 32'd1);
    host_read(4'd4, 32'hA5A5_0000 + 32'(gen_cnt));
    host_write(4'd2, 32'd1);
    check("irq_after_clear", 32'(irq), 32'd0);

    // three entries, durations 1,2,1
    host_write(4'd8,  32'h0001_000A);
    host_write(4'd9,  32'h0002_0014);
    host_write(4'd10, 32'h0001_001E);
    host_write(4'd3, 32'd3);
    host_read(4'd9, 32'h0002_0014);
    push_w(2'd0, 32'd10);
    push_w(2'd1, 32'd3);
    push_ack();
    push_w(2'd0, 32'd20);
    push_ack();
    push_ack();
    push_w(2'd0, 32'd30);
    push_ack();
    push_w(2'd1, 32'd0);
    host_write(4'd0, 32'h9);
    for (int i = 0; i < 4; i++) fire_irq();
    idle(3);
    host_read(4'd1, 32'h22);
    host_read(4'd4, 32'hA5A5_0000 + 32'(gen_cnt));

    // duration 0 counts as one period
    host_write(4'd8, 32'h0000_0005);
    host_write(4'd3, 32'd1);
    push_w(2'd0, 32'd5);
    push_w(2'd1, 32'd3);
    push_ack();
    push_w(2'd1, 32'd0);
    host_write(4'd0, 32'h1);
    fire_irq();
    idle(3);
    host_read(4'd1, 32'h2);
    check("irq_masked", 32'(irq), 32'd0);

    // LEN=0 START and START+STOP produce no traffic
    host_write(4'd3, 32'd0);
    host_write(4'd0, 32'h1);
    idle(5);
    host_read(4'd1, 32'h2);
    host_write(4'd3, 32'd2);
    host_write(4'd0, 32'h3);
    idle(5);
    host_read(4'd1, 32'h2);
    host_write(4'd3, 32'd12);
    host_read(4'd3, 32'd8);
    host_write(4'd0, 32'hC);
    host_read(4'd0, CTRL_RB);

    // reset while waiting for an interrupt
    host_write(4'd3, 32'd1);
    push_w(2'd0, 32'd5);
    push_w(2'd1, 32'd3);
    host_write(4'd0, 32'h1);
    idle(5);
    host_read(4'd1, 32'h0001_0001);
    idle(2);
    ResetN = 1'b0;
    #1;
    check("midrun_reset_ReadData", ReadData, 32'd0);
    check("midrun_reset_ctl_outs", 32'({irq, sw_ChipSelect, sw_Write, sw_Read, sw_Address}), 32'd0);
    idle(2);
    ResetN = 1'b1;
    idle(1);
    host_read(4'd3, 32'd0);
    host_read(4'd8, 32'd0);
    host_write(4'd8, 32'h0001_0028);
    host_write(4'd9, 32'h0001_0032);
    host_write(4'd3, 32'd2);
    push_w(2'd0, 32'h28);
    push_w(2'd1, 32'd3);
    host_write(4'd0, 32'h1);
    idle(5);
    host_read(4'd1, 32'h0001_0001);
    push_ack();
    push_w(2'd0, 32'h32);
    fire_irq();
    host_read(4'd1, 32'h0001_0011);
    push_w(2'd1, 32'd0);
    host_write(4'd0, 32'h2);
    idle(5);
    host_read(4'd1, 32'h0001_0010);

`ifdef SEQ_LOOP_EN
    // looping two-entry sequence, then host STOP
    push_w(2'd0, 32'h28);
    push_w(2'd1, 32'd3);
    push_ack(); push_w(2'd0, 32'h32);
    push_ack(); push_w(2'd0, 32'h28);
    push_ack(); push_w(2'd0, 32'h32);
    push_ack(); push_w(2'd0, 32'h28);
    host_write(4'd0, 32'h5);
    for (int i = 0; i < 4; i++) fire_irq();
    host_read(4'd1, 32'h0001_0001);
    push_w(2'd1, 32'd0);
    host_write(4'd0, 32'h6);
    idle(5);
    host_read(4'd1, 32'h0001_0000);
`endif

    idle(3);
    check("sw_queue_drained", 32'(sw_q.size()), 32'd0);
    check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
